fsm_stim_sequencer: RTL
=======================

Name: fsm_stim_sequencer

Overview:
Controller that sequences the team's two-flop sequential machine (state {A,B}; A⁺ = x; B⁺ = AB + B·x' + A'B'x).
- Shifts a programmed x pattern into the machine one bit per clock, LSB first.
- Captures the resulting state after every step into a trace, and counts visits to a programmable target state.
- Sits beside the machine on the same clk/res and owns its x input; gives a start/done handshake to a host or testbench.

Parameters:
- LEN, 8, maximum pattern length in steps (≥2).
- CW, $clog2(LEN+1), width of the length field and the step counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- res  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  cancels a run in progress.
- pattern  input  LEN  x bits; bit k is applied at step k.
- len  input  CW  number of steps; values above LEN are clamped to LEN.
- target  input  2  state value {A,B} to count.
- st_in  input  2  current machine state {A,B}.
- x_out  output  1  drives the machine's x input.
- busy  output  1  high in RUN and FLUSH.
- done  output  1  one-cycle completion pulse.
- trace  output  2*LEN  slot k = trace[2k+1:2k] = state after step k; unused slots are 0.
- hit_count  output  CW  number of trace slots equal to target.

Behaviour:
- Clock and reset: single clock clk. Reset res is asynchronous, active-low. While res=0: state=IDLE, x_out=0, busy=0, done=0, trace=0, hit_count=0, internal pattern/len/step registers = 0.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - x_out=0.
  - On start=1, latch pattern, min(len,LEN) and target, then clear trace and hit_count.
  - If latched len=0, go to DONE; otherwise go to RUN with step=0.
- RUN, step k:
  - x_out = pat_reg[k].
  - If k≥1, capture st_in into slot k-1 (st_in reflects step k-1, one-cycle machine latency). Increment hit_count if it matches target.
  - k increments each cycle. After step len-1, go to FLUSH.
- FLUSH:
  - x_out=0.
  - Capture st_in into slot len-1 with the same hit rule, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Results hold: trace and hit_count hold until the next accepted start.
- Latency: first x bit appears in the cycle after the start edge. done is asserted len+1 cycles after the first RUN cycle.
- start while busy or in DONE: ignored, with no effect on the run.
- abort=1 in RUN or FLUSH:
  - Next state is IDLE, x_out=0 immediately at the next edge, no done pulse.
  - trace/hit_count keep the partial contents.
  - abort in IDLE or DONE is ignored.
  - abort and start together in IDLE: start wins.
- Reset mid-run: asynchronous return to IDLE with all outputs cleared. The machine shares res, so both restart from 00.
- Width rules:
  - hit_count saturates at LEN; it cannot exceed len by construction.
  - The step counter is CW bits wide and never wraps within a run.

Decomposition:
- Shared package fsm_stim_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2, DONE=2'd3);
  - the default LEN;
  - the machine-state constants S00..S11.
- One sub-module, fsm_stim_trace: trace slot write (index, value, enable) plus the target comparator and hit counter, cleared by a clear strobe from the FSM.

Test Plan:
- Reset, then start with pattern=8'b0001_0011, len=5, target=2'b01 → x_out sequence 1,1,0,0,1; trace[9:0]=10'b10_01_01_11_11; hit_count=2; done pulses exactly once, 6 cycles after the first RUN cycle; busy high for 6 cycles.
- len=0, start → no x activity; done on the cycle after the start edge; trace=0, hit_count=0.
- len=12 with LEN=8, pattern=8'hFF, target=2'b11 → 8 steps run; all slots 11; hit_count=8.
- start pulsed again at step 2 of a len=5 run → ignored; run completes with the values of the first scenario.
- abort at step 3 of the first scenario's run → IDLE next edge, x_out=0, no done; slots 0–1 = 11,11, slot 2 = 01, hit_count=1.
- res driven low at step 2, released, new start with the same stimulus → outputs cleared during reset; rerun reproduces the first scenario exactly.

Source files
------------

// File: rtl/fsm_stim_pkg.sv
// Shared types and constants for the stimulus sequencer and its trace block.
package fsm_stim_pkg;

    localparam int unsigned DefaultLen = 8;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StRun   = 2'd1;
    localparam state_t StFlush = 2'd2;
    localparam state_t StDone  = 2'd3;

    // Machine state encodings {A,B}
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

endpackage

// File: rtl/fsm_stim_sequencer_if.sv
// Host/machine-facing bundle of the stimulus sequencer.
interface fsm_stim_sequencer_if import fsm_stim_pkg::*; #(
    parameter int unsigned LEN = DefaultLen,
    parameter int unsigned CW  = $clog2(LEN + 1)
);
    logic                 start;
    logic                 abort;
    logic [LEN-1:0]       pattern;
    logic [CW-1:0]        len;
    logic [1:0]           target;
    logic [1:0]           st_in;
    logic                 x_out;
    logic                 busy;
    logic                 done;
    logic [2*LEN-1:0]     trace;
    logic [CW-1:0]        hit_count;

    modport master (
        output start, abort, pattern, len, target, st_in,
        input  x_out, busy, done, trace, hit_count
    );

    modport slave (
        input  start, abort, pattern, len, target, st_in,
        output x_out, busy, done, trace, hit_count
    );
endinterface

// File: rtl/fsm_stim_trace.sv
// Trace slot storage plus target comparator and saturating hit counter.
module fsm_stim_trace import fsm_stim_pkg::*; #(
    parameter int unsigned LEN = DefaultLen,
    parameter int unsigned CW  = $clog2(LEN + 1)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [CW-1:0]      wr_idx,
    input  logic [1:0]         wr_val,
    input  logic [1:0]         target,
    output logic [2*LEN-1:0]   trace,
    output logic [CW-1:0]      hit_count
);
    logic [2*LEN-1:0] trace_q, trace_d;
    logic [CW-1:0]    hit_q, hit_d;

    always_comb begin
        trace_d = trace_q;
        hit_d   = hit_q;
        for (int i = 0; i < int'(LEN); i++) begin
            if (wr_en && wr_idx == CW'(i)) trace_d[2*i +: 2] = wr_val;
        end
        if (wr_en && wr_val == target && hit_q < CW'(LEN)) hit_d = hit_q + CW'(1);
        if (clear) begin
            trace_d = '0;
            hit_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            trace_q <= '0;
            hit_q   <= '0;
        end else begin
            trace_q <= trace_d;
            hit_q   <= hit_d;
        end
    end

    assign trace     = trace_q;
    assign hit_count = hit_q;
endmodule

// File: rtl/fsm_stim_sequencer.sv
// Shifts a programmed x pattern into the two-flop machine and records its state trace.
module fsm_stim_sequencer import fsm_stim_pkg::*; #(
    parameter int unsigned LEN = DefaultLen,
    parameter int unsigned CW  = $clog2(LEN + 1)
) (
    input  logic                 clk,
    input  logic                 res,
    fsm_stim_sequencer_if.slave  bus
);
    state_t           state_q, state_d;
    logic [LEN-1:0]   pat_q, pat_d;
    logic [CW-1:0]    len_q, len_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [CW-1:0]    step_q, step_d;
    logic [CW-1:0]    len_clamped;
    logic [LEN-1:0]   pat_sh;
    logic             clear;
    logic             wr_en;
    logic [CW-1:0]    wr_idx;

    assign len_clamped = (bus.len > CW'(LEN)) ? CW'(LEN) : bus.len;
    assign pat_sh      = pat_q >> step_q;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    pat_d   = bus.pattern;
                    len_d   = len_clamped;
                    tgt_d   = bus.target;
                    step_d  = '0;
                    clear   = 1'b1;
                    state_d = (len_clamped == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // st_in lags x by one cycle, so step k records the result of step k-1
                if (step_q != '0) begin
                    wr_en  = 1'b1;
                    wr_idx = step_q - CW'(1);
                end
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (step_q == len_q - CW'(1)) begin
                    state_d = StFlush;
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            StFlush: begin
                wr_en   = 1'b1;
                wr_idx  = len_q - CW'(1);
                state_d = bus.abort ? StIdle : StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= StIdle;
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
        end
    end

    assign bus.x_out = (state_q == StRun) ? pat_sh[0] : 1'b0;
    assign bus.busy  = (state_q == StRun) || (state_q == StFlush);
    assign bus.done  = (state_q == StDone);

    fsm_stim_trace #(
        .LEN (LEN),
        .CW  (CW)
    ) u_trace (
        .clk       (clk),
        .res       (res),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_val    (bus.st_in),
        .target    (tgt_q),
        .trace     (bus.trace),
        .hit_count (bus.hit_count)
    );
endmodule
